// File: rtl/bf16_to_fp8_packer.sv
// bf16_to_fp8_packer
//   Requantizer on the drain side of the systolic array. It converts BF16
//   results to FP8 E4M3 (OCP variant: bias 7, no Inf, 0x7F/0xFF is NaN) and
//   packs PACK bytes per output word for write-back as next-layer operands.
//   Two-stage valid/ready pipeline: stage 1 converts, stage 2 packs.
//
//   Parameters
//     PACK       FP8 lanes per output word (1, 2, 4 or 8)
//   Ports
//     clk        clock, rising edge
//     rst_n      asynchronous active-low reset
//     in_valid   input beat valid
//     in_ready   beat accepted this cycle when in_valid is also high
//     in_bf16    BF16 value {sign, exp[7:0], man[6:0]}
//     in_last    final element of a row; flushes a partial word
//     out_valid  output word valid
//     out_ready  downstream accepts the word
//     out_data   packed FP8 bytes, lane 0 in [7:0], unused upper lanes zero
//     out_bytes  number of valid lanes in out_data (1..PACK)
//     out_last   word contains the in_last element
//     out_sat    at least one lane in the word saturated or was NaN
//   Optional (macro FP8Q_STATS_EN)
//     sat_cnt    finite/Inf inputs that saturated (sticks at 0xFFFF)
//     nan_cnt    NaN inputs (sticks at 0xFFFF)
//     uflow_cnt  nonzero inputs that became +/-0 (sticks at 0xFFFF)

module bf16_to_fp8_packer #(
    parameter int PACK = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [15:0]         in_bf16,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*PACK-1:0]   out_data,
    output logic [3:0]          out_bytes,
    output logic                out_last,
    output logic                out_sat
`ifdef FP8Q_STATS_EN
    ,
    output logic [15:0]         sat_cnt,
    output logic [15:0]         nan_cnt,
    output logic [15:0]         uflow_cnt
`endif
);

    localparam int IW = (PACK > 1) ? $clog2(PACK) : 1;

    // Whole pipeline moves together: it only stalls when a finished word
    // is sitting in the output register and nobody takes it.
    logic advance;
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    // ------------------------------------------------------------------
    // Conversion (combinational, feeds stage 1)
    // ------------------------------------------------------------------
    logic       sgn;
    logic [7:0] ex;
    logic [6:0] mn;
    logic [7:0] sig;     // 1.man as an integer with 7 fraction bits
    logic [7:0] nrm;     // {exp4, man3} before the saturation clamp
    logic       rnd;
    logic [2:0] sq;      // subnormal integer part before rounding
    logic       sg, ss;  // subnormal guard / sticky
    logic [3:0] sub;     // subnormal mantissa after rounding, 0..8
    logic [6:0] cv_mag;
    logic       cv_sat;
    logic [7:0] cv_byte;

    assign sgn = in_bf16[15];
    assign ex  = in_bf16[14:7];
    assign mn  = in_bf16[6:0];
    assign sig = {1'b1, mn};

    always_comb begin
        cv_mag = 7'h00;
        cv_sat = 1'b0;
        nrm    = 8'h00;
        rnd    = 1'b0;
        sq     = 3'd0;
        sg     = 1'b0;
        ss     = 1'b0;
        sub    = 4'd0;
        if (ex == 8'hFF) begin
            // NaN keeps the NaN code; Inf clamps to max finite (+/-448)
            cv_mag = (mn != 7'd0) ? 7'h7F : 7'h7E;
            cv_sat = 1'b1;
        end else if (ex == 8'd0) begin
            cv_mag = 7'h00;                       // zero and BF16 subnormals
        end else if (ex > 8'd135) begin
            cv_mag = 7'h7E;                       // |x| >= 512
            cv_sat = 1'b1;
        end else if (ex >= 8'd121) begin
            // Normal range. RNE on man[3:0]; a mantissa carry simply ripples
            // into the exponent field of the concatenated code.
            rnd = mn[3] & ((|mn[2:0]) | mn[4]);
            nrm = ((ex - 8'd120) << 3) + {5'd0, mn[6:4]} + {7'd0, rnd};
            if (nrm > 8'h7E) begin
                cv_mag = 7'h7E;                   // 480 and up would hit NaN
                cv_sat = 1'b1;
            end else begin
                cv_mag = nrm[6:0];
            end
        end else if (ex >= 8'd117) begin
            // Subnormal range: mantissa = RNE(1.man * 2^(e+9)). A result of
            // 8 lands on code 0x08, which is exactly the minimum normal.
            case (ex)
                8'd120:  begin sq = sig[7:5];         sg = sig[4]; ss = |sig[3:0]; end
                8'd119:  begin sq = {1'b0, sig[7:6]}; sg = sig[5]; ss = |sig[4:0]; end
                8'd118:  begin sq = {2'b0, sig[7]};   sg = sig[6]; ss = |sig[5:0]; end
                default: begin sq = 3'd0;             sg = sig[7]; ss = |sig[6:0]; end
            endcase
            sub    = {1'b0, sq} + {3'd0, sg & (ss | sq[0])};
            cv_mag = {3'd0, sub};
        end
    end

    assign cv_byte = {sgn, cv_mag};

    // ------------------------------------------------------------------
    // Stage 1 register
    // ------------------------------------------------------------------
    logic       s1_valid;
    logic [7:0] s1_byte;
    logic       s1_last;
    logic       s1_sat;
`ifdef FP8Q_STATS_EN
    logic       s1_nan;
    logic       s1_uflow;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_byte  <= 8'h00;
            s1_last  <= 1'b0;
            s1_sat   <= 1'b0;
`ifdef FP8Q_STATS_EN
            s1_nan   <= 1'b0;
            s1_uflow <= 1'b0;
`endif
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_byte  <= cv_byte;
            s1_last  <= in_last;
            s1_sat   <= cv_sat;
`ifdef FP8Q_STATS_EN
            s1_nan   <= (ex == 8'hFF) && (mn != 7'd0);
            s1_uflow <= (in_bf16[14:0] != 15'd0) && (cv_mag == 7'h00);
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: pack
    // ------------------------------------------------------------------
    logic [IW-1:0]          idx;
    logic [PACK-1:0][7:0]   buf_q;
    logic [PACK-1:0][7:0]   merged;
    logic                   word_sat;
    logic                   done;

    // Buffer with the incoming byte dropped into its lane. Lanes above idx
    // are still zero from the last clear, so a flushed partial word is
    // already zero-padded.
    for (genvar l = 0; l < PACK; l++) begin : g_lane
        assign merged[l] = (s1_valid && idx == IW'(l)) ? s1_byte : buf_q[l];
    end

    assign done = s1_valid & ((idx == IW'(PACK - 1)) | s1_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            buf_q     <= '0;
            word_sat  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_bytes <= 4'd0;
            out_last  <= 1'b0;
            out_sat   <= 1'b0;
        end else if (advance) begin
            out_valid <= done;
            if (s1_valid) begin
                if (done) begin
                    out_data  <= merged;
                    out_bytes <= 4'(idx) + 4'd1;
                    out_last  <= s1_last;
                    out_sat   <= word_sat | s1_sat;
                    idx       <= '0;
                    buf_q     <= '0;
                    word_sat  <= 1'b0;
                end else begin
                    buf_q     <= merged;
                    word_sat  <= word_sat | s1_sat;
                    idx       <= idx + 1'b1;
                end
            end
        end
    end

`ifdef FP8Q_STATS_EN
    // One event per byte consumed by the packer; counters stick at max.
    logic consume;
    assign consume = advance & s1_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt   <= 16'd0;
            nan_cnt   <= 16'd0;
            uflow_cnt <= 16'd0;
        end else if (consume) begin
            if (s1_sat && !s1_nan && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 16'd1;
            if (s1_nan && nan_cnt != 16'hFFFF)             nan_cnt <= nan_cnt + 16'd1;
            if (s1_uflow && uflow_cnt != 16'hFFFF)         uflow_cnt <= uflow_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bf16_to_fp8_packer.sv
// Scoreboard bench for bf16_to_fp8_packer (PACK=4). Each accepted beat puts
// its expected FP8 byte into a model word; finished words are queued and
// compared against the DUT output when it is handed downstream.

module tb_bf16_to_fp8_packer;

    localparam int PACK = 4;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_bf16;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [8*PACK-1:0] out_data;
    logic [3:0]        out_bytes;
    logic              out_last;
    logic              out_sat;
`ifdef FP8Q_STATS_EN
    logic [15:0]       sat_cnt, nan_cnt, uflow_cnt;
`endif

    bf16_to_fp8_packer #(.PACK(PACK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bf16   (in_bf16),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_bytes (out_bytes),
        .out_last  (out_last),
        .out_sat   (out_sat)
`ifdef FP8Q_STATS_EN
        ,
        .sat_cnt   (sat_cnt),
        .nan_cnt   (nan_cnt),
        .uflow_cnt (uflow_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  bytes;
        logic        last;
        logic        sat;
        int          lat;    // expected cycle of appearance, -1 = don't care
    } word_t;

    word_t       sb[$];
    logic [31:0] m_word;
    int          m_idx;
    logic        m_sat;
    int          n_chk = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_word = 32'h0;
        m_idx  = 0;
        m_sat  = 1'b0;
    endtask

    // Drive one beat; returns #1 after the accepting edge. in_valid stays high
    // so back-to-back calls stream one beat per cycle.
    task automatic send(input logic [15:0] v, input logic last,
                        input logic [7:0] eb, input logic es, input logic lat_chk);
        bit    acc = 0;
        int    n   = 0;
        word_t w;
        in_bf16  = v;
        in_last  = last;
        in_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            n++;
        end
        #1;
        chk("accept", acc, 1);
        if (acc) begin
            m_word[m_idx*8 +: 8] = eb;
            m_sat = m_sat | es;
            if (last || m_idx == PACK - 1) begin
                w.data  = m_word;
                w.bytes = 4'(m_idx + 1);
                w.last  = last;
                w.sat   = m_sat;
                w.lat   = lat_chk ? cyc + 1 : -1;
                sb.push_back(w);
                model_clear();
            end else begin
                m_idx++;
            end
        end
    endtask

    // Output monitor: every word taken downstream must match the queue head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_word", out_data, 0);
            end else begin
                word_t w;
                w = sb.pop_front();
                chk("out_data",  out_data,  w.data);
                chk("out_bytes", out_bytes, w.bytes);
                chk("out_last",  out_last,  w.last);
                chk("out_sat",   out_sat,   w.sat);
                if (w.lat >= 0) chk("latency", cyc, w.lat);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bf16   = 16'h0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        model_clear();

        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data",  out_data,  0);
        chk("rst_out_bytes", out_bytes, 0);
        chk("rst_out_last",  out_last,  0);
        chk("rst_out_sat",   out_sat,   0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic row: 1.0, 2.0, -1.5 (0xBC), 448 (max finite, not saturated)
        send(16'h3F80, 0, 8'h38, 0, 0);
        send(16'h4000, 0, 8'h40, 0, 0);
        send(16'hBFC0, 0, 8'hBC, 0, 0);
        send(16'h43E0, 1, 8'h7E, 0, 1);

        // Saturation / NaN: 512, -Inf, NaN, 480 (rounds into NaN code -> clamp)
        send(16'h4400, 0, 8'h7E, 1, 0);
        send(16'hFF80, 0, 8'hFE, 1, 0);
        send(16'h7FC1, 0, 8'h7F, 1, 0);
        send(16'h43F0, 1, 8'h7E, 1, 0);

        // Rounding and subnormals; full word without last, then a flush
        send(16'h3F90, 0, 8'h39, 0, 0);   // 1.125
        send(16'h3F88, 0, 8'h38, 0, 0);   // 1.0625 tie -> even
        send(16'h3B00, 0, 8'h01, 0, 0);   // 2^-9
        send(16'h3A80, 0, 8'h00, 0, 0);   // 2^-10 tie -> 0
        send(16'h8000, 0, 8'h80, 0, 0);   // -0 kept
        send(16'h3C7F, 1, 8'h08, 0, 0);   // rounds up to min normal

        // Partial flush, then the next word restarts at lane 0
        send(16'h3F80, 0, 8'h38, 0, 0);
        send(16'h4000, 1, 8'h40, 0, 0);
        send(16'h3F80, 1, 8'h38, 0, 0);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: word completes while out_ready=0, fifth beat stalls
        out_ready = 1'b0;
        send(16'h3F80, 0, 8'h38, 0, 0);
        send(16'h4000, 0, 8'h40, 0, 0);
        send(16'h3F90, 0, 8'h39, 0, 0);
        send(16'h3F88, 0, 8'h38, 0, 0);
        send(16'h3B00, 0, 8'h01, 0, 0);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready",  in_ready,  0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_data",  out_data,  32'h38394038);
            @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
        send(16'h4000, 1, 8'h40, 0, 0);   // joins the stalled byte in lane 1
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Async reset mid-word (two lanes buffered)
        send(16'h3F80, 0, 8'h38, 0, 0);
        send(16'h4000, 0, 8'h40, 0, 0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data",  out_data,  0);
        chk("arst_out_bytes", out_bytes, 0);
        chk("arst_out_last",  out_last,  0);
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(16'h4000, 0, 8'h40, 0, 0);
        send(16'h3F80, 0, 8'h38, 0, 0);
        send(16'h3F90, 0, 8'h39, 0, 0);
        send(16'h8000, 1, 8'h80, 0, 0);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
